// File: rtl/priority_encoder_reg.sv
// priority_encoder_reg: registered MSB-first priority encoder; PRIO_ENC_ONEHOT_EN adds a registered one-hot output
module priority_encoder_reg #(
  parameter int WIDTH = 4,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
`ifdef PRIO_ENC_ONEHOT_EN
  output logic [WIDTH-1:0] y_onehot,
`endif
  output logic [OUT_W-1:0] y,
  output logic             valid
);
  logic [OUT_W-1:0] y_nxt;
  logic [WIDTH-1:0] oh_nxt;
  // Ascending scan where the last hit wins; unknown lower bits never take the branch, so a known higher 1 decides.
  always_comb begin
    y_nxt = '0;
    oh_nxt = '0;
    for (int k = 0; k < WIDTH; k++)
      if (i[k]) begin
        y_nxt = OUT_W'(k);
        oh_nxt = WIDTH'(1) << k;
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      y <= '0;
      valid <= 1'b0;
    end else if (en) begin
      y <= y_nxt;
      valid <= |i;
    end
`ifdef PRIO_ENC_ONEHOT_EN
  always_ff @(posedge clk)
    if (rst) y_onehot <= '0;
    else if (en) y_onehot <= oh_nxt;
`else
  logic unused_oh;
  assign unused_oh = ^oh_nxt;
`endif
endmodule

// File: tb/tb_priority_encoder_reg.sv
// tb_priority_encoder_reg: directed vector table plus hand sequences for reset, hold and wider builds
module tb_priority_encoder_reg;
  logic clk = 0;
  logic rst = 1;
  logic en = 0;
  logic [3:0] i = '0;
  logic [4:0] i5 = '0;
  logic [7:0] i8 = '0;
  logic [1:0] y;
  logic [2:0] y5, y8;
  logic valid, valid5, valid8;
  int checks = 0;
  int errors = 0;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [3:0] oh;
  logic [4:0] oh5;
  logic [7:0] oh8;
`endif
  always #5 clk = ~clk;

  priority_encoder_reg dut (
    .clk(clk), .rst(rst), .en(en), .i(i),
`ifdef PRIO_ENC_ONEHOT_EN
    .y_onehot(oh),
`endif
    .y(y), .valid(valid));
  priority_encoder_reg #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .i(i5),
`ifdef PRIO_ENC_ONEHOT_EN
    .y_onehot(oh5),
`endif
    .y(y5), .valid(valid5));
  priority_encoder_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .i(i8),
`ifdef PRIO_ENC_ONEHOT_EN
    .y_onehot(oh8),
`endif
    .y(y8), .valid(valid8));

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] v;
    logic [1:0] y;
    logic       valid;
    logic [3:0] oh;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] v);
    @(negedge clk);
    rst = r;
    en = e;
    i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string name, input logic [1:0] ey, input logic ev, input logic [3:0] eoh);
    chk({name, ".y"}, 64'(y), 64'(ey));
    chk({name, ".valid"}, 64'(valid), 64'(ev));
`ifdef PRIO_ENC_ONEHOT_EN
    chk({name, ".onehot"}, 64'(oh), 64'(eoh));
`else
    if (eoh === 4'bxxxx) chk({name, ".onehot_ref"}, 64'(eoh), 64'(0));
`endif
  endtask

  function automatic logic [1:0] ref_y(input logic [3:0] v);
    for (int k = 3; k >= 0; k--) if (v[k] === 1'b1) return 2'(k);
    return 2'd0;
  endfunction

  initial begin
    vecs = '{
      '{1, 1, 4'b1111, 0, 0, 4'b0000},
      '{1, 1, 4'b1111, 0, 0, 4'b0000},
      '{0, 1, 4'b1111, 3, 1, 4'b1000},
      '{0, 1, 4'b0001, 0, 1, 4'b0001},
      '{0, 1, 4'b0010, 1, 1, 4'b0010},
      '{0, 1, 4'b0100, 2, 1, 4'b0100},
      '{0, 1, 4'b1000, 3, 1, 4'b1000},
      '{0, 1, 4'b01xx, 2, 1, 4'b0100},
      '{0, 1, 4'b1x1x, 3, 1, 4'b1000},
      '{0, 1, 4'b0011, 1, 1, 4'b0010},
      '{0, 1, 4'b0000, 0, 0, 4'b0000},
      '{0, 0, 4'b1000, 0, 0, 4'b0000},
      '{0, 0, 4'b1000, 0, 0, 4'b0000},
      '{0, 0, 4'b1000, 0, 0, 4'b0000},
      '{0, 1, 4'b1000, 3, 1, 4'b1000},
      '{0, 1, 4'b0100, 2, 1, 4'b0100},
      '{0, 1, 4'b1001, 3, 1, 4'b1000},
      '{0, 1, 4'b0011, 1, 1, 4'b0010},
      '{0, 0, 4'b1000, 1, 1, 4'b0010},
      '{1, 0, 4'b1111, 0, 0, 4'b0000},
      '{0, 1, 4'b0001, 0, 1, 4'b0001}
    };
    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].r, vecs[n].e, vecs[n].v);
      chk4($sformatf("vec%0d", n), vecs[n].y, vecs[n].valid, vecs[n].oh);
    end
    // Reset arriving while enabled overrides the capture; the next capture is normal.
    step(0, 1, 4'b1000);
    chk4("pre_rst", 2'd3, 1'b1, 4'b1000);
    step(1, 1, 4'b0100);
    chk4("mid_rst", 2'd0, 1'b0, 4'b0000);
    step(0, 1, 4'b0010);
    chk4("post_rst", 2'd1, 1'b1, 4'b0010);
    for (int n = 0; n < 20; n++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      step(0, 1, v);
      chk4($sformatf("rand%0d_%b", n, v), ref_y(v), |v, (v == 0) ? 4'b0000 : 4'b0001 << ref_y(v));
    end
    @(negedge clk);
    i5 = 5'b10000;
    i8 = 8'b00100101;
    step(0, 1, 4'b0000);
    chk("w5.y", 64'(y5), 64'd4);
    chk("w5.valid", 64'(valid5), 64'd1);
    chk("w8.y", 64'(y8), 64'd5);
    chk("w8.valid", 64'(valid8), 64'd1);
`ifdef PRIO_ENC_ONEHOT_EN
    chk("w5.onehot", 64'(oh5), 64'h10);
    chk("w8.onehot", 64'(oh8), 64'h20);
`endif
    @(negedge clk);
    i5 = 5'b00111;
    i8 = 8'b00000000;
    step(0, 1, 4'b0000);
    chk("w5b.y", 64'(y5), 64'd2);
    chk("w8b.y", 64'(y8), 64'd0);
    chk("w8b.valid", 64'(valid8), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
